// File: rtl/serial_adder_if.sv
// Operand/result bundle between a requester and the bit-serial adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    // Requester side: issues operands, observes status and result.
    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout, overflow
    );

    // Adder side: consumes operands, produces status and result.
    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell plus a carry flop, LSB first.
// Result registers hold their value from the done pulse until the next
// operation completes, so sum/cout/overflow stay stable between done pulses.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [WIDTH-1:0]   r_sum_sh;
    logic               r_carry;
    logic [CNT_W-1:0]   r_cnt;

    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    logic               w_s;
    logic               w_c;
    logic               w_last;
    logic               w_accept;
    logic [WIDTH:0]     w_sum_ext;

    // Full-adder cell on the current LSBs and the shifted-in sum word.
    always_comb begin
        w_s       = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
        w_c       = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
        w_sum_ext = {w_s, r_sum_sh};
        w_last    = (r_state == S_RUN) && (r_cnt == CNT_W'(WIDTH - 1));
        w_accept  = (r_state == S_IDLE) && bus.start;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last)    w_state_nxt = S_DONE;
            S_DONE:                 w_state_nxt = S_IDLE;
            default:                w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-bit shifting and result latch on the final bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_sum_sh <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_sum    <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a_sh   <= bus.a;
            r_b_sh   <= bus.b;
            r_carry  <= bus.cin;
            r_cnt    <= '0;
            r_sum_sh <= '0;
        end else if (r_state == S_RUN) begin
            r_a_sh   <= r_a_sh >> 1;
            r_b_sh   <= r_b_sh >> 1;
            r_sum_sh <= w_sum_ext[WIDTH:1];
            r_carry  <= w_c;
            r_cnt    <= r_cnt + CNT_W'(1);
            if (w_last) begin
                // Old carry is the carry into the MSB; w_c is the carry out.
                r_sum  <= w_sum_ext[WIDTH:1];
                r_cout <= w_c;
                r_ovf  <= r_carry ^ w_c;
            end
        end
    end

    // Registered status flags derived from the upcoming state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.sum      = r_sum;
    assign bus.cout     = r_cout;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: directed vector table, multi-cycle corner sequences
// and a random sweep against an arithmetic model, for WIDTH=8 and WIDTH=1.
module tb_serial_adder;

    logic clk;
    logic rst_n;

    int n_checks;
    int n_fail;

    serial_adder_if #(.WIDTH(8)) if8 ();
    serial_adder_if #(.WIDTH(1)) if1 ();

    serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));
    serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One WIDTH=8 operation; returns result plus observed latency and busy cycles.
    task automatic op8(input logic [7:0] a_i, input logic [7:0] b_i, input logic c_i,
                       output logic [7:0] s_o, output logic co, output logic ov,
                       output int lat, output int nbusy);
        @(posedge clk); #1;
        if8.start = 1'b1; if8.a = a_i; if8.b = b_i; if8.cin = c_i;
        @(posedge clk); #1;
        if8.start = 1'b0; if8.a = 8'h00; if8.b = 8'h00; if8.cin = 1'b0;
        lat = 0; nbusy = 0;
        while (!if8.done && lat < 40) begin
            if (if8.busy) nbusy++;
            @(posedge clk); #1;
            lat++;
        end
        s_o = if8.sum; co = if8.cout; ov = if8.overflow;
    endtask

    task automatic op1(input logic a_i, input logic b_i, input logic c_i,
                       output logic s_o, output logic co, output logic ov, output int lat);
        @(posedge clk); #1;
        if1.start = 1'b1; if1.a = a_i; if1.b = b_i; if1.cin = c_i;
        @(posedge clk); #1;
        if1.start = 1'b0;
        lat = 0;
        while (!if1.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        s_o = if1.sum; co = if1.cout; ov = if1.overflow;
    endtask

    vec_t vecs [12];

    initial begin
        logic [7:0] s8;
        logic       co, ov;
        logic       s1;
        int         lat, nbusy;
        logic [8:0] ref9;
        logic [1:0] ref2;
        logic       ref_ov;
        logic [7:0] ra, rb;
        logic       ra1, rb1, rc;
        int         ndone, last_done, stable_bad, interval_bad, cyc, wait_cyc;
        logic [7:0] cap_sum;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2]  = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
        vecs[3]  = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[4]  = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[5]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[6]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[7]  = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[9]  = '{8'h7F, 8'h7F, 1'b0, 8'hFE, 1'b0, 1'b1};
        vecs[10] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[11] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.cin = 1'b0;
        if1.start = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;

        // Reset state.
        #12;
        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_done", 32'(if8.done), 32'd0);
        check("rst_sum",  32'(if8.sum),  32'd0);
        check("rst_cout", 32'(if8.cout), 32'd0);
        check("rst_ovf",  32'(if8.overflow), 32'd0);
        #10 rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            op8(vecs[i].a, vecs[i].b, vecs[i].cin, s8, co, ov, lat, nbusy);
            check($sformatf("vec%0d_sum", i),  32'(s8),  32'(vecs[i].exp_sum));
            check($sformatf("vec%0d_cout", i), 32'(co),  32'(vecs[i].exp_cout));
            check($sformatf("vec%0d_ovf", i),  32'(ov),  32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_lat", i),  32'(lat), 32'd8);
            check($sformatf("vec%0d_busy", i), 32'(nbusy), 32'd8);
            @(posedge clk); #1;
            check($sformatf("vec%0d_done_pulse", i), 32'(if8.done), 32'd0);
        end

        // Start pulsed mid-RUN must be dropped.
        @(posedge clk); #1;
        if8.start = 1'b1; if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        if8.start = 1'b1; if8.a = 8'h01; if8.b = 8'h01;
        @(posedge clk); #1;
        if8.start = 1'b0;
        ndone = 0; cap_sum = 8'h00;
        for (int k = 0; k < 25; k++) begin
            if (if8.done) begin ndone++; cap_sum = if8.sum; end
            @(posedge clk); #1;
        end
        check("busy_start_ndone", 32'(ndone), 32'd1);
        check("busy_start_sum",   32'(cap_sum), 32'h30);

        // Asynchronous reset in the middle of an operation.
        @(posedge clk); #1;
        if8.start = 1'b1; if8.a = 8'hAA; if8.b = 8'h55;
        @(posedge clk); #1;
        if8.start = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(if8.busy), 32'd0);
        check("midrst_done", 32'(if8.done), 32'd0);
        check("midrst_sum",  32'(if8.sum),  32'd0);
        check("midrst_cout", 32'(if8.cout), 32'd0);
        check("midrst_ovf",  32'(if8.overflow), 32'd0);
        #7 rst_n = 1'b1;
        op8(8'h0F, 8'h01, 1'b0, s8, co, ov, lat, nbusy);
        check("postrst_sum", 32'(s8), 32'h10);
        check("postrst_lat", 32'(lat), 32'd8);

        // Start held high: back-to-back operations every WIDTH+2 cycles.
        @(posedge clk); #1;
        if8.start = 1'b1; if8.a = 8'h80; if8.b = 8'h80; if8.cin = 1'b0;
        ndone = 0; last_done = -1; stable_bad = 0; interval_bad = 0;
        for (cyc = 1; cyc <= 35; cyc++) begin
            @(posedge clk); #1;
            if (if8.done) begin
                ndone++;
                check("hold_sum",  32'(if8.sum),  32'h00);
                check("hold_cout", 32'(if8.cout), 32'd1);
                check("hold_ovf",  32'(if8.overflow), 32'd1);
                if (last_done >= 0 && cyc - last_done != 10) interval_bad++;
                last_done = cyc;
            end else if (last_done >= 0 && if8.sum !== 8'h00) begin
                stable_bad++;
            end
        end
        if8.start = 1'b0;
        check("hold_ndone",    32'(ndone), 32'd3);
        check("hold_interval", 32'(interval_bad), 32'd0);
        check("hold_stable",   32'(stable_bad), 32'd0);
        wait_cyc = 0;
        while (!if8.done && wait_cyc < 30) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        check("hold_drain", 32'(wait_cyc < 30), 32'd1);

        // Random sweep, WIDTH=8.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            ref9   = 9'(ra) + 9'(rb) + 9'(rc);
            ref_ov = (ra[7] == rb[7]) && (ref9[7] != ra[7]);
            op8(ra, rb, rc, s8, co, ov, lat, nbusy);
            n_checks++;
            if ({co, s8} !== ref9 || ov !== ref_ov || lat != 8) begin
                n_fail++;
                $display("FAIL rand8 %0d: a=%0h b=%0h cin=%0b got sum=%0h cout=%0b ovf=%0b lat=%0d expected sum=%0h cout=%0b ovf=%0b lat=8",
                         n, ra, rb, rc, s8, co, ov, lat, ref9[7:0], ref9[8], ref_ov);
            end
        end

        // Random sweep, WIDTH=1 (single RUN cycle, carry into MSB is cin).
        for (int n = 0; n < 1000; n++) begin
            ra1 = 1'($urandom); rb1 = 1'($urandom); rc = 1'($urandom);
            ref2   = 2'(ra1) + 2'(rb1) + 2'(rc);
            ref_ov = (ra1 == rb1) && (ref2[0] != ra1);
            op1(ra1, rb1, rc, s1, co, ov, lat);
            n_checks++;
            if ({co, s1} !== ref2 || ov !== ref_ov || lat != 1) begin
                n_fail++;
                $display("FAIL rand1 %0d: a=%0b b=%0b cin=%0b got sum=%0b cout=%0b ovf=%0b lat=%0d expected sum=%0b cout=%0b ovf=%0b lat=1",
                         n, ra1, rb1, rc, s1, co, ov, lat, ref2[0], ref2[1], ref_ov);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder: the addition counterpart to the team's combinational full subtractor.
- Loads two WIDTH-bit operands and a carry-in on a start pulse.
- Adds one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop.
- Reports sum, carry-out and signed overflow with a one-cycle done pulse.
- Used where area matters more than latency in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when result valid.
- sum  output  WIDTH  result; valid from done, held until next accepted start.
- cout  output  1  final carry-out.
- overflow  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (any time, including mid-operation) forces:
  - state=IDLE, busy=0, done=0;
  - sum=0, cout=0, overflow=0;
  - shift registers, carry and bit counter = 0.
  - The in-flight operation is discarded.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at a clock edge loads a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, sum_sh<=0 and moves to RUN.
  - sum/cout/overflow keep their previous values until the first RUN edge.
- RUN, each edge:
  - s = a_sh[0]^b_sh[0]^carry;
  - c = (a_sh[0]&b_sh[0]) | (carry&(a_sh[0]^b_sh[0]));
  - sum_sh shifts right with s entering at the MSB; a_sh and b_sh shift right;
  - carry<=c; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1:
    - record carry-into-MSB = old carry;
    - move to DONE.
- DONE, for exactly one cycle:
  - done=1;
  - sum=sum_sh (bit 0 = first computed bit);
  - cout=carry; overflow=carry-into-MSB XOR carry.
  - Next edge returns to IDLE unconditionally.
- busy=1 exactly in RUN. done=1 exactly in DONE.
- Latency:
  - start accepted at edge T → RUN for edges T+1..T+WIDTH → done high in the cycle after edge T+WIDTH.
  - Throughput: one operation per WIDTH+2 cycles.
- start in RUN or DONE is ignored (not queued). Operands may change freely after capture.
- start held high continuously: a new operation is accepted in each IDLE cycle, i.e. back-to-back every WIDTH+2 cycles.
- WIDTH=1: a single RUN cycle; carry-into-MSB = cin.
- Arithmetic is unsigned modulo 2^WIDTH with cout as bit WIDTH. overflow interprets a, b and sum as two's complement.
- cnt width is clog2(WIDTH)+1.

Test Plan:
- Basic add, WIDTH=8: a=0x5A, b=0x33, cin=0 → busy for 8 cycles; done 9 cycles after start edge; sum=0x8D, cout=0, overflow=1.
- Carry ripple: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, overflow=0. Then a=0x7F, b=0x00, cin=1 → sum=0x80, cout=0, overflow=1.
- Start while busy: second start with a=0x01, b=0x01 pulsed mid-RUN of 0x10+0x20 → result 0x30; exactly one done; the second request is lost.
- Reset mid-operation: assert rst_n=0 at RUN cycle 4 of 0xAA+0x55 → busy, done, sum, cout and overflow all 0 immediately (asynchronous). After release, a fresh 0x0F+0x01 gives sum=0x10.
- Hold and back-to-back: start held high with a=0x80, b=0x80, cin=0 → done every 10 cycles; sum=0x00, cout=1, overflow=1 each time; sum stable between done pulses.
- Random sweep: 1000 random a/b/cin for WIDTH=8 and WIDTH=1 vs reference model {cout,sum}=a+b+cin → zero mismatches.
